// File: rtl/fp_acc_seq.sv
// Sequencer that streams FP operands into an external adder and accumulates each vector's sum.
// Optional synchronous abort port clear_i is enabled by defining FP_ACC_SEQ_CLEAR_EN.
module fp_acc_seq #(
  parameter int unsigned C_OP    = 16,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef FP_ACC_SEQ_CLEAR_EN
  input  logic            clear_i,
`endif
  input  logic [C_OP-1:0] in_data_i,
  input  logic            in_last_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [C_OP-1:0] add_a_o,
  output logic [C_OP-1:0] add_b_o,
  input  logic [C_OP-1:0] add_res_i,
  output logic [C_OP-1:0] out_data_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [C_OP-1:0]  acc_q, acc_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_c;

`ifdef FP_ACC_SEQ_CLEAR_EN
  assign clr_c = clear_i;
`else
  assign clr_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accumulator always feeds operand A; the adder result is only consumed in WAIT
  assign add_a_o = acc_q;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    add_b_o     = '0;
    busy_o      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        in_ready_o = ~clr_c;
        // First element is loaded verbatim so -0 and NaN payloads survive untouched
        if (in_valid_i && !clr_c) begin
          acc_d   = in_data_i;
          state_d = in_last_i ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        in_ready_o = ~clr_c;
        add_b_o    = in_data_i;
        if (in_valid_i && !clr_c) begin
          last_d  = in_last_i;
          cnt_d   = CNT_W'(ADD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          acc_d   = add_res_i;
          state_d = last_q ? OUT : ACCUM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        out_valid_o = 1'b1;
        out_data_o  = acc_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Synchronous abort wins over everything, including a pending output
    if (clr_c) begin
      state_d = IDLE;
      acc_d   = '0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end
  end

endmodule
